// File: rtl/winograd_pkg.sv
// rtl/winograd_pkg.sv - shared types and constants for the Winograd input transform
//
// Purpose: tile-mode encodings, default element widths and 6x6 tile array types
//          shared by winograd_input_transform and winograd_bt_1d.
// Ports:   none (package).

package winograd_pkg;

    localparam int TILE_N      = 6;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_GUARD_W = 7;
    localparam int DEF_OUT_W   = DEF_DATA_W + DEF_GUARD_W;

    // Tile mode as sampled alongside each accepted tile.
    typedef enum logic {
        MODE_F2X2 = 1'b0,   // F(2x2,3x3): 4x4 input tile
        MODE_F4X4 = 1'b1    // F(4x4,3x3): 6x6 input tile
    } mode_e;

    // 6x6 tiles indexed [row][col], at the default input and output widths.
    typedef logic [TILE_N-1:0][TILE_N-1:0][DEF_DATA_W-1:0] tile_in_t;
    typedef logic [TILE_N-1:0][TILE_N-1:0][DEF_OUT_W-1:0]  tile_out_t;

endpackage

// File: rtl/winograd_bt_1d.sv
// rtl/winograd_bt_1d.sv - combinational 1-D B^T product on a 6-element vector
//
// Purpose: y = B^T x for either tile mode, using shifts and add/subtract only.
//          All arithmetic is W bits wide and wraps modulo 2^W.
// Ports:
//   mode  in   tile mode (MODE_F2X2 uses x[0:3] and drives y[4:5] to zero)
//   x     in   6 x W input vector
//   y     out  6 x W transformed vector

module winograd_bt_1d
    import winograd_pkg::*;
#(
    parameter int W = DEF_OUT_W
) (
    input  logic                     mode,
    input  logic [TILE_N-1:0][W-1:0] x,
    output logic [TILE_N-1:0][W-1:0] y
);

    always_comb begin
        y = '0;
        if (mode == MODE_F4X4) begin
            y[0] = (x[0] << 2) - (x[2] << 2) - x[2] + x[4];
            y[1] = x[3] + x[4] - (x[1] << 2) - (x[2] << 2);
            y[2] = (x[1] << 2) - (x[2] << 2) - x[3] + x[4];
            y[3] = (x[3] << 1) - (x[1] << 1) - x[2] + x[4];
            y[4] = (x[1] << 1) - (x[3] << 1) - x[2] + x[4];
            y[5] = (x[1] << 2) - (x[3] << 2) - x[3] + x[5];
        end else begin
            y[0] = x[0] - x[2];
            y[1] = x[1] + x[2];
            y[2] = x[2] - x[1];
            y[3] = x[1] - x[3];
        end
    end

endmodule

// File: rtl/winograd_input_transform.sv
// rtl/winograd_input_transform.sv - two-stage pipelined Winograd input transform V = B^T d B
//
// Purpose: S1 registers T = B^T d (column transforms), S2 registers V = T B
//          (row transforms). Mode travels with each tile; valid/ready handshake
//          on both sides, one tile per cycle when the consumer is ready.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clr              synchronous flush of both stages (data registers kept)
//   mode             tile mode sampled with each accepted tile
//   in_valid/ready   input handshake for tile_in/mode
//   tile_in          6x6 signed input tile [row][col], DATA_W per element
//   out_valid/ready  output handshake for tile_out/out_mode
//   tile_out         6x6 signed transformed tile, OUT_W per element
//   out_mode         mode of the tile on tile_out
//   busy             either stage holds a tile

module winograd_input_transform
    import winograd_pkg::*;
#(
    parameter int  DATA_W  = DEF_DATA_W,
    parameter int  GUARD_W = DEF_GUARD_W,
    localparam int OUT_W   = DATA_W + GUARD_W
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clr,
    input  logic                                     mode,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [TILE_N-1:0][TILE_N-1:0][DATA_W-1:0] tile_in,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [TILE_N-1:0][TILE_N-1:0][OUT_W-1:0]  tile_out,
    output logic                                     out_mode,
    output logic                                     busy
);

    // Column-major copies ([col][row]) let each column feed one 1-D instance.
    logic [TILE_N-1:0][TILE_N-1:0][OUT_W-1:0] d_cm;
    logic [TILE_N-1:0][TILE_N-1:0][OUT_W-1:0] t_cm;
    logic [TILE_N-1:0][TILE_N-1:0][OUT_W-1:0] t_next;
    logic [TILE_N-1:0][TILE_N-1:0][OUT_W-1:0] v_next;
    logic [TILE_N-1:0][TILE_N-1:0][OUT_W-1:0] s1_data;
    logic [TILE_N-1:0][TILE_N-1:0][OUT_W-1:0] s2_data;
    logic s1_valid, s1_mode;
    logic s2_valid, s2_mode;
    logic s1_load, s2_load, accept;

    always_comb begin
        d_cm = '0;
        for (int r = 0; r < TILE_N; r++) begin
            for (int c = 0; c < TILE_N; c++) begin
                d_cm[c][r] = {{GUARD_W{tile_in[r][c][DATA_W-1]}}, tile_in[r][c]};
            end
        end
    end

    always_comb begin
        t_next = '0;
        for (int r = 0; r < TILE_N; r++) begin
            for (int c = 0; c < TILE_N; c++) begin
                t_next[r][c] = t_cm[c][r];
            end
        end
    end

    // In 4x4 mode the 1-D transform only reads elements 0..3 and zeroes 4..5,
    // so tile_in rows/cols 4-5 never reach V and V rows/cols 4-5 come out zero.
    for (genvar g = 0; g < TILE_N; g++) begin : g_stage
        winograd_bt_1d #(.W(OUT_W)) u_col (
            .mode (mode),
            .x    (d_cm[g]),
            .y    (t_cm[g])
        );
        winograd_bt_1d #(.W(OUT_W)) u_row (
            .mode (s1_mode),
            .x    (s1_data[g]),
            .y    (v_next[g])
        );
    end

    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s2_mode  <= 1'b0;
            s1_data  <= '0;
            s2_data  <= '0;
        end else begin
            if (clr) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s2_load) s2_valid <= s1_valid;
                if (s1_load) s1_valid <= accept;
            end
            if (s2_load && s1_valid) begin
                s2_data <= v_next;
                s2_mode <= s1_mode;
            end
            if (accept) begin
                s1_data <= t_next;
                s1_mode <= mode;
            end
        end
    end

    assign out_valid = s2_valid;
    assign tile_out  = s2_data;
    assign out_mode  = s2_mode;
    assign busy      = s1_valid || s2_valid;

endmodule
